// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: AHB-Lite master that fills the IFB under a credit rule and handles redirects.
// Define FETCH_CHECKSUM_EN to drive a SECDED checksum of each pushed instruction word on s_checksum_o.
module fetch_ctrl #(
   parameter int          IFB_SIZE  = 2,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
   localparam int         IFB_WIDTH = 38
) (
   input  logic                 s_clk_i,
   input  logic                 s_resetn_i,
   input  logic                 s_redirect_i,
   input  logic [31:0]          s_redirect_addr_i,
   input  logic [IFB_SIZE-1:0]  s_ifb_occupied_i,
   input  logic                 s_ifb_pop_i,
   input  logic                 s_hready_i,
   input  logic                 s_hresp_i,
   input  logic [31:0]          s_hrdata_i,
   output logic [31:0]          s_haddr_o,
   output logic [1:0]           s_htrans_o,
   output logic                 s_push_o,
   output logic [IFB_WIDTH-1:0] s_data_o,
   output logic [6:0]           s_checksum_o
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] FETCH_VALID   = 3'b001;
   localparam logic [2:0] FETCH_BSERR   = 3'b010;
   localparam int         CW            = $clog2(IFB_SIZE + 2) + 1;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HOLD,
      ST_REDIR
   } state_t;

   state_t state, state_next;

   logic [31:0]   pc, pc_next, redir_addr, redirect_target, fetch_word;
   logic          dp_pending, dp_discard, ap_stall;
   logic [CW-1:0] occ_count;
   logic          credit_ok, nonseq, accept, stall_now, complete, push;
   logic [2:0]    status;

   always_comb begin
      occ_count = '0;
      for (int i = 0; i < IFB_SIZE; i++) begin
         occ_count = occ_count + CW'(s_ifb_occupied_i[i]);
      end
   end

   // Pop is added on the right-hand side so the comparison never underflows.
   assign credit_ok       = (occ_count + CW'(dp_pending)) < (CW'(IFB_SIZE) + CW'(s_ifb_pop_i));
   assign redirect_target = s_redirect_addr_i & ~32'h3;

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state <= ST_BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_BOOT:  state_next = ST_RUN;
         ST_RUN: begin
            if (s_redirect_i && stall_now) begin
               state_next = ST_REDIR;
            end else if (!nonseq) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD:  if (credit_ok) state_next = ST_RUN;
         ST_REDIR: if (accept) state_next = ST_RUN;
         default:  state_next = ST_BOOT;
      endcase
   end

   // A stalled address phase keeps NONSEQ asserted whatever the credit does meanwhile.
   always_comb begin
      nonseq = 1'b0;
      case (state)
         ST_RUN:   nonseq = ap_stall | credit_ok;
         ST_REDIR: nonseq = 1'b1;
         default:  nonseq = 1'b0;
      endcase
   end

   assign accept    = nonseq & s_hready_i;
   assign stall_now = nonseq & ~s_hready_i;
   assign complete  = dp_pending & s_hready_i;
   assign push      = complete & ~dp_discard & ~s_redirect_i;

   always_comb begin
      pc_next = pc;
      if (state == ST_REDIR) begin
         if (accept) pc_next = s_redirect_i ? redirect_target : redir_addr;
      end else if (s_redirect_i && !stall_now) begin
         pc_next = redirect_target;
      end else if (accept) begin
         pc_next = pc + 32'd4;
      end
   end

   // Anything accepted during a redirect, or while one is pending, is wrong-path and gets discarded.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         pc         <= BOOT_ADDR;
         redir_addr <= '0;
         dp_pending <= 1'b0;
         dp_discard <= 1'b0;
         ap_stall   <= 1'b0;
      end else begin
         pc       <= pc_next;
         ap_stall <= stall_now;
         if (s_redirect_i && stall_now) begin
            redir_addr <= redirect_target;
         end
         if (s_hready_i) begin
            dp_pending <= accept;
            dp_discard <= accept & (s_redirect_i | (state == ST_REDIR));
         end else begin
            dp_discard <= dp_discard | s_redirect_i;
         end
      end
   end

   assign status     = s_hresp_i ? FETCH_BSERR : FETCH_VALID;
   assign fetch_word = (push && !s_hresp_i) ? s_hrdata_i : 32'h0;

   assign s_haddr_o  = pc;
   assign s_htrans_o = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign s_push_o   = push;
   assign s_data_o   = push ? {2'b00, status, 1'b0, fetch_word} : '0;

`ifdef FETCH_CHECKSUM_EN
   // Hamming(38,32) with check bits at power-of-two positions, plus an overall parity bit in [6].
   function automatic logic [6:0] secded_encode(input logic [31:0] d);
      logic [38:0] cw;
      logic [5:0]  c;
      int          k;
      cw = '0;
      c  = '0;
      k  = 0;
      for (int p = 1; p < 39; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[k];
            k++;
         end
      end
      for (int p = 1; p < 39; p++) begin
         for (int b = 0; b < 6; b++) begin
            if (p[b]) c[b] = c[b] ^ cw[p];
         end
      end
      return {(^d) ^ (^c), c};
   endfunction

   assign s_checksum_o = secded_encode(fetch_word);
`else
   assign s_checksum_o = 7'b0;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter IFB_SIZE, default 2, number of IFB entries fed by this block (≥2).
REQ-002 Parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-003 Ports (clock and reset first):
 s_clk_i  in  1  clock; single clock domain, all state on rising edge.
 s_resetn_i  in  1  reset, asynchronous, active-low.
 s_redirect_i  in  1  pipeline redirect/flush request.
 s_redirect_addr_i  in  32  new fetch address, bits [1:0] ignored.
 s_ifb_occupied_i  in  IFB_SIZE  occupancy vector of downstream IFB.
 s_ifb_pop_i  in  1  IFB pops an entry this cycle.
 s_hready_i  in  1  AHB-Lite ready.
 s_hresp_i  in  1  AHB-Lite error response.
 s_hrdata_i  in  32  AHB-Lite read data.
 s_haddr_o  out  32  fetch address (word aligned).
 s_htrans_o  out  2  2'b00 IDLE / 2'b10 NONSEQ.
 s_push_o  out  1  push entry into IFB.
 s_data_o  out  IFB_WIDTH  IFB entry: [37:36] RAS prediction = 2'b00, [35:33] fetch status, [32] = 0, [31:0] instruction.
 s_checksum_o  out  7  SECDED checksum of s_data_o[31:0].

Function
REQ-004 AHB-Lite pipelined: address phase accepted when s_htrans_o=NONSEQ and s_hready_i=1; data phase completes in a later cycle with s_hready_i=1.
REQ-005 At most one address phase and one data phase outstanding.
REQ-006 Credit rule: NONSEQ only if popcount(s_ifb_occupied_i) + data-phase-pending − s_ifb_pop_i < IFB_SIZE; otherwise s_htrans_o=IDLE.
REQ-007 While address phase waits (s_hready_i=0), s_haddr_o and s_htrans_o SHALL stay stable.
REQ-008 Accepted address phase advances fetch PC by 4; wrap 32'hFFFF_FFFC → 0.
REQ-009 Data phase completion with s_hresp_i=0: s_push_o=1 same cycle, status FETCH_VALID, data = s_hrdata_i.
REQ-010 Completion with s_hresp_i=1: s_push_o=1, status FETCH_BSERR, data = 0; fetching continues at next PC.
REQ-011 Redirect with no pending address phase: s_haddr_o = s_redirect_addr_i & ~3 next cycle if credit allows; PC = redirect+4 after acceptance.
REQ-012 Redirect while address phase stalled: address latched into pending-redirect register; current transfer completes on bus, is discarded, then redirect address issued.
REQ-013 Any transfer in data phase when s_redirect_i=1 is marked discard; its completion SHALL NOT assert s_push_o.
REQ-014 Redirect in same cycle as data-phase completion: completion discarded, s_push_o=0.
REQ-015 Back-to-back redirects: last one wins; earlier pending address overwritten.
REQ-016 State machine: BOOT (one cycle after reset, IDLE), RUN (issuing), HOLD (no credit, IDLE), REDIR (pending redirect waits for stalled address phase); BOOT→RUN; RUN↔HOLD on credit; RUN→REDIR on REQ-012; REDIR→RUN on acceptance.
REQ-017 Full throughput: with credit and s_hready_i=1, one push per cycle after two-cycle initial latency.

Reset
REQ-018 Asynchronous reset: state BOOT, PC = BOOT_ADDR, no pending phases, discard flags cleared, pending redirect cleared.
REQ-019 Outputs during reset: s_htrans_o=2'b00, s_haddr_o=BOOT_ADDR, s_push_o=0, s_data_o=0, s_checksum_o=0.
REQ-020 Reset mid-transfer: outstanding response dropped, no push after deassertion until new fetch completes.

Configuration
REQ-021 Macro FETCH_CHECKSUM_EN defined: s_checksum_o = SECDED encode of s_hrdata_i, driven with every push (BSERR entries encode 0).
REQ-022 Macro undefined: s_checksum_o tied 7'b0, no encoder instantiated.

Verification
REQ-023 Reset, hready=1, empty IFB -> NONSEQ at 0x0, 0x4; pushes FETCH_VALID with hrdata values cycles 2, 3.
REQ-024 IFB_SIZE=2, both occupied, no pop -> htrans IDLE; one pop -> single NONSEQ, exactly one push.
REQ-025 hready=0 for 3 cycles during address phase at 0x8, redirect to 0x100 -> 0x8 held, its data discarded, next NONSEQ 0x100.
REQ-026 hresp=1 on fetch at 0x10 -> push status FETCH_BSERR, data 0; next NONSEQ 0x14.
REQ-027 Redirect to 0x200 coinciding with completion -> no push; following push carries data from 0x200.
REQ-028 PC 0xFFFF_FFFC fetch -> next address 0x0; with FETCH_CHECKSUM_EN, hrdata 0x0000_0013 -> s_checksum_o equals SECDED encode of 0x13.
